// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi frame controller and its output aligner.
package viterbi_pkg;

    localparam int SYM_W       = 2;
    localparam int K_MIN       = 3;
    localparam int K_MAX       = 6;
    localparam int FRAME_LEN_W = 9;
    localparam int SYM_CNT_W   = 10;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_TAIL,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic len_legal(input logic [FRAME_LEN_W-1:0] len, input int max_len);
        return (len != '0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/vit_out_align.sv
// Turns a qualifying decoder enable into a registered output bit two cycles later,
// flagging the final bit of the frame from the running output count.
module vit_out_align
    import viterbi_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   qual_en,
    input  logic                   dec_bit,
    input  logic [FRAME_LEN_W-1:0] out_cnt,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    output logic                   take,
    output logic                   out_valid,
    output logic                   out_bit,
    output logic                   out_last
);

    logic qual_q, qual_d;
    logic valid_q, valid_d;
    logic bit_q, bit_d;
    logic last_q, last_d;

    // dec_bit belongs to the enable of the previous cycle, so capture it while qual_q is high.
    always_comb begin
        qual_d  = qual_en;
        valid_d = qual_q;
        bit_d   = qual_q ? dec_bit : 1'b0;
        last_d  = qual_q && (out_cnt == (frame_len - 1'b1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qual_q  <= 1'b0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            qual_q  <= qual_d;
            valid_q <= valid_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
        end
    end

    assign take      = qual_q;
    assign out_valid = valid_q;
    assign out_bit   = bit_q;
    assign out_last  = last_q;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer around the hard-decision Viterbi core: clears it, feeds the frame
// plus zero flush symbols, and qualifies the decoded bits that come back out.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int K             = 3,
    parameter int TB_DEPTH      = 15,
    parameter int MAX_FRAME_LEN = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] frame_len,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_sym,
    output logic       dec_clr,
    output logic       dec_en,
    output logic [1:0] dec_sym,
    input  logic       dec_bit,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int K_EFF = (K < K_MIN) ? K_MIN : ((K > K_MAX) ? K_MAX : K);
    // The zero run must both terminate the trellis (K-1) and flush traceback (TB_DEPTH-1).
    localparam int FLUSH_LEN  = (TB_DEPTH > K_EFF) ? (TB_DEPTH - 1) : (K_EFF - 1);
    localparam int QUAL_START = TB_DEPTH - 1;

    state_e                 state_q, state_d;
    logic [FRAME_LEN_W-1:0] frame_len_q, frame_len_d;
    logic [SYM_CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [FRAME_LEN_W-1:0] out_cnt_q, out_cnt_d;
    logic                   err_q, err_d;

    logic [SYM_CNT_W-1:0]   last_data_idx;
    logic [SYM_CNT_W-1:0]   last_sym_idx;
    logic                   qual_en;
    logic                   take;
    sym_t                   dec_sym_c;

    assign last_data_idx = {1'b0, frame_len_q} - 10'd1;
    assign last_sym_idx  = {1'b0, frame_len_q} + 10'(FLUSH_LEN - 1);

    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        sym_cnt_d   = sym_cnt_q;
        out_cnt_d   = out_cnt_q;
        err_d       = 1'b0;
        in_ready    = 1'b0;
        dec_clr     = 1'b0;
        dec_en      = 1'b0;
        dec_sym_c   = '0;

        if (take) begin
            out_cnt_d = out_cnt_q + 9'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_legal(frame_len, MAX_FRAME_LEN)) begin
                        frame_len_d = frame_len;
                        state_d     = ST_CLR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLR: begin
                dec_clr   = 1'b1;
                sym_cnt_d = '0;
                out_cnt_d = '0;
                state_d   = ST_FEED;
            end
            ST_FEED: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dec_en    = 1'b1;
                    dec_sym_c = in_sym;
                    sym_cnt_d = sym_cnt_q + 10'd1;
                    if (sym_cnt_q == last_data_idx) begin
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                dec_en    = 1'b1;
                sym_cnt_d = sym_cnt_q + 10'd1;
                if (sym_cnt_q == last_sym_idx) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frame_len_q <= '0;
            sym_cnt_q   <= '0;
            out_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_len_q <= frame_len_d;
            sym_cnt_q   <= sym_cnt_d;
            out_cnt_q   <= out_cnt_d;
            err_q       <= err_d;
        end
    end

    // Only symbols past the traceback depth produce a decided bit.
    assign qual_en = dec_en && (sym_cnt_q >= 10'(QUAL_START));

    vit_out_align u_out_align (
        .clk       (clk),
        .rst_n     (rst_n),
        .qual_en   (qual_en),
        .dec_bit   (dec_bit),
        .out_cnt   (out_cnt_q),
        .frame_len (frame_len_q),
        .take      (take),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    assign dec_sym = dec_sym_c;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a mock decoder that returns data bit j
// one cycle after the enable of symbol j+TB_DEPTH-1.
module tb_viterbi_frame_ctrl;

    localparam int TB = 15;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [8:0] frame_len;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sym;
    logic       dec_clr;
    logic       dec_en;
    logic [1:0] dec_sym;
    logic       dec_bit;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    logic [1:0] stim [0:299];
    logic [1:0] hist [0:299];
    logic       out_bits [0:299];
    int         mock_idx;

    logic mon_clr = 1'b0;
    int   en_cnt, zero_cnt, hs_cnt, hs_bad, ov_cnt, last_cnt, last_idx;
    int   done_cnt, err_cnt, clr_cnt, pace_bad, m_idx;
    int   clr_cyc, first_ov_cyc, done_cyc;
    logic [1:0] pipe;

    viterbi_frame_ctrl #(.K(3), .TB_DEPTH(TB), .MAX_FRAME_LEN(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .dec_clr   (dec_clr),
        .dec_en    (dec_en),
        .dec_sym   (dec_sym),
        .dec_bit   (dec_bit),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mock decoder: bit j is the high bit of the symbol fed at index j.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mock_idx <= 0;
            dec_bit  <= 1'b0;
        end else if (dec_clr) begin
            mock_idx <= 0;
        end else if (dec_en) begin
            hist[mock_idx] <= dec_sym;
            dec_bit        <= (mock_idx >= TB - 1) ? hist[mock_idx - (TB - 1)][1] : 1'b1;
            mock_idx       <= mock_idx + 1;
        end
    end

    // Monitor: event counts, capture of output bits and the two-cycle pacing rule.
    always @(negedge clk) begin
        if (!rst_n || mon_clr) begin
            en_cnt <= 0; zero_cnt <= 0; hs_cnt <= 0; hs_bad <= 0; ov_cnt <= 0;
            last_cnt <= 0; last_idx <= -1; done_cnt <= 0; err_cnt <= 0; clr_cnt <= 0;
            pace_bad <= 0; m_idx <= 0; pipe <= 2'b00;
            clr_cyc <= 0; first_ov_cyc <= 0; done_cyc <= 0;
        end else begin
            if (dec_clr) begin
                clr_cnt <= clr_cnt + 1;
                clr_cyc <= cyc;
                m_idx   <= 0;
            end else if (dec_en) begin
                m_idx <= m_idx + 1;
            end
            if (dec_en) begin
                en_cnt <= en_cnt + 1;
                if (dec_sym == 2'b00) zero_cnt <= zero_cnt + 1;
            end
            if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
            if (in_ready && ((dec_en !== in_valid) || (!in_valid && dec_sym !== 2'b00)))
                hs_bad <= hs_bad + 1;
            if (out_valid !== pipe[1]) pace_bad <= pace_bad + 1;
            pipe <= {pipe[0], dec_en && (m_idx >= TB - 1)};
            if (out_valid) begin
                if (ov_cnt == 0) first_ov_cyc <= cyc;
                if (ov_cnt < 300) out_bits[ov_cnt] <= out_bit;
                ov_cnt <= ov_cnt + 1;
                if (out_last) begin
                    last_cnt <= last_cnt + 1;
                    last_idx <= ov_cnt;
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (err) err_cnt <= err_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // mode 0: always valid, 1: valid toggles 1,0,1,0 from the first FEED cycle, 2: random.
    task automatic run_frame(input int len, input int mode, input bit inject,
                             input int abort_at, output bit finished);
        int sent;
        int inj;
        finished = 1'b0;
        for (int i = 0; i < len; i++) stim[i] = 2'($urandom_range(1, 3));
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        frame_len = 9'(len);
        t0        = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        sent  = 0;
        inj   = 0;
        for (int c = 1; c < len * 4 + 200; c++) begin
            if (c == abort_at) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            if (sent < len) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (c % 2 == 0);
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
            end else begin
                in_valid = 1'b0;
            end
            in_sym = in_valid ? stim[sent] : 2'($urandom_range(0, 3));
            start  = 1'b0;
            if (inject && sent >= 2 && inj < 2) begin
                start     = 1'b1;
                frame_len = (inj == 0) ? 9'd0 : 9'd3;
                inj++;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (done) finished = 1'b1;
            @(posedge clk);
            #1;
            if (finished) break;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; frame_len = 9'd0; in_valid = 1'b0; in_sym = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, dec_clr, dec_en, dec_sym, out_valid, out_bit, out_last, busy, done, err} !== 11'b0)
            $display("[TB] FAIL reset_outputs: got %b expected 0",
                     {in_ready, dec_clr, dec_en, dec_sym, out_valid, out_bit, out_last, busy, done, err});
        if ({in_ready, dec_clr, dec_en, dec_sym, out_valid, out_bit, out_last, busy, done, err} !== 11'b0)
            errors++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got busy=%b in_ready=%b expected 0 0", busy, in_ready);
        end
    endtask

    task automatic test_min_frame();
        bit fin;
        run_frame(4, 0, 1'b0, 0, fin);
        checks++; if (fin !== 1'b1) begin errors++; $display("[TB] FAIL min_done_seen: got %0d expected 1", fin); end
        checks++; if (en_cnt !== 18) begin errors++; $display("[TB] FAIL min_dec_en: got %0d expected 18", en_cnt); end
        checks++; if (zero_cnt !== 14) begin errors++; $display("[TB] FAIL min_zero_syms: got %0d expected 14", zero_cnt); end
        checks++; if (ov_cnt !== 4) begin errors++; $display("[TB] FAIL min_out_cnt: got %0d expected 4", ov_cnt); end
        checks++; if (last_cnt !== 1 || last_idx !== 3) begin errors++; $display("[TB] FAIL min_last: got cnt %0d idx %0d expected 1 3", last_cnt, last_idx); end
        checks++; if (clr_cyc - t0 !== 1) begin errors++; $display("[TB] FAIL min_clr_cycle: got %0d expected 1", clr_cyc - t0); end
        checks++; if (first_ov_cyc - t0 !== 18) begin errors++; $display("[TB] FAIL min_first_out_cycle: got %0d expected 18", first_ov_cyc - t0); end
        checks++; if (done_cyc - t0 !== 22) begin errors++; $display("[TB] FAIL min_done_cycle: got %0d expected 22", done_cyc - t0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL min_busy_after_done: got %b expected 0", busy); end
        checks++; if (pace_bad !== 0) begin errors++; $display("[TB] FAIL min_pacing: got %0d expected 0", pace_bad); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_bits[j] !== stim[j][1]) begin
                errors++;
                $display("[TB] FAIL min_bit%0d: got %b expected %b", j, out_bits[j], stim[j][1]);
            end
        end
    endtask

    task automatic test_stall();
        bit fin;
        run_frame(8, 1, 1'b0, 0, fin);
        checks++; if (fin !== 1'b1) begin errors++; $display("[TB] FAIL stall_done_seen: got %0d expected 1", fin); end
        checks++; if (hs_cnt !== 8) begin errors++; $display("[TB] FAIL stall_handshakes: got %0d expected 8", hs_cnt); end
        checks++; if (en_cnt !== 22) begin errors++; $display("[TB] FAIL stall_dec_en: got %0d expected 22", en_cnt); end
        checks++; if (hs_bad !== 0) begin errors++; $display("[TB] FAIL stall_en_follows_handshake: got %0d expected 0", hs_bad); end
        checks++; if (pace_bad !== 0) begin errors++; $display("[TB] FAIL stall_pacing: got %0d expected 0", pace_bad); end
        checks++; if (ov_cnt !== 8 || last_idx !== 7) begin errors++; $display("[TB] FAIL stall_outputs: got %0d last %0d expected 8 7", ov_cnt, last_idx); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (out_bits[j] !== stim[j][1]) begin
                errors++;
                $display("[TB] FAIL stall_bit%0d: got %b expected %b", j, out_bits[j], stim[j][1]);
            end
        end
    endtask

    task automatic test_illegal_len();
        int bad_len [2];
        bad_len[0] = 0;
        bad_len[1] = 257;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            start     = 1'b1;
            frame_len = 9'(bad_len[i]);
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_%0d_err: got err=%b busy=%b expected 1 0", bad_len[i], err, busy);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_%0d_after: got err=%b busy=%b expected 0 0", bad_len[i], err, busy);
            end
        end
    endtask

    task automatic test_max_frame();
        bit fin;
        run_frame(256, 2, 1'b0, 0, fin);
        checks++; if (fin !== 1'b1) begin errors++; $display("[TB] FAIL max_done_seen: got %0d expected 1", fin); end
        checks++; if (ov_cnt !== 256) begin errors++; $display("[TB] FAIL max_out_cnt: got %0d expected 256", ov_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL max_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (last_cnt !== 1 || last_idx !== 255) begin errors++; $display("[TB] FAIL max_last: got cnt %0d idx %0d expected 1 255", last_cnt, last_idx); end
        checks++; if (en_cnt !== 270) begin errors++; $display("[TB] FAIL max_dec_en: got %0d expected 270", en_cnt); end
        checks++; if (pace_bad !== 0 || hs_bad !== 0) begin errors++; $display("[TB] FAIL max_pacing: got %0d/%0d expected 0/0", pace_bad, hs_bad); end
        for (int j = 0; j < 256; j++) begin
            checks++;
            if (out_bits[j] !== stim[j][1]) begin
                errors++;
                $display("[TB] FAIL max_bit%0d: got %b expected %b", j, out_bits[j], stim[j][1]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit fin;
        run_frame(6, 0, 1'b0, 12, fin);
        #1;
        checks++;
        if ({in_ready, dec_clr, dec_en, dec_sym, out_valid, out_bit, out_last, busy, done, err} !== 11'b0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %b expected 0",
                     {in_ready, dec_clr, dec_en, dec_sym, out_valid, out_bit, out_last, busy, done, err});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(5, 0, 1'b0, 0, fin);
        checks++; if (fin !== 1'b1) begin errors++; $display("[TB] FAIL abort_next_done: got %0d expected 1", fin); end
        checks++; if (clr_cnt !== 1) begin errors++; $display("[TB] FAIL abort_next_clr: got %0d expected 1", clr_cnt); end
        checks++; if (ov_cnt !== 5 || last_idx !== 4) begin errors++; $display("[TB] FAIL abort_next_outputs: got %0d last %0d expected 5 4", ov_cnt, last_idx); end
        checks++; if (done_cyc - t0 !== 23) begin errors++; $display("[TB] FAIL abort_next_done_cycle: got %0d expected 23", done_cyc - t0); end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (out_bits[j] !== stim[j][1]) begin
                errors++;
                $display("[TB] FAIL abort_next_bit%0d: got %b expected %b", j, out_bits[j], stim[j][1]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit fin;
        run_frame(6, 0, 1'b1, 0, fin);
        checks++; if (fin !== 1'b1) begin errors++; $display("[TB] FAIL busy_start_done: got %0d expected 1", fin); end
        checks++; if (err_cnt !== 0) begin errors++; $display("[TB] FAIL busy_start_err: got %0d expected 0", err_cnt); end
        checks++; if (clr_cnt !== 1 || done_cnt !== 1) begin errors++; $display("[TB] FAIL busy_start_single_frame: got clr %0d done %0d expected 1 1", clr_cnt, done_cnt); end
        checks++; if (ov_cnt !== 6 || last_idx !== 5) begin errors++; $display("[TB] FAIL busy_start_outputs: got %0d last %0d expected 6 5", ov_cnt, last_idx); end
        checks++; if (done_cyc - t0 !== 24) begin errors++; $display("[TB] FAIL busy_start_done_cycle: got %0d expected 24", done_cyc - t0); end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (out_bits[j] !== stim[j][1]) begin
                errors++;
                $display("[TB] FAIL busy_start_bit%0d: got %b expected %b", j, out_bits[j], stim[j][1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit fin;
        run_frame(1, 0, 1'b0, 0, fin);
        checks++; if (fin !== 1'b1) begin errors++; $display("[TB] FAIL len1_done_seen: got %0d expected 1", fin); end
        checks++; if (hs_cnt !== 1 || en_cnt !== 15) begin errors++; $display("[TB] FAIL len1_symbols: got hs %0d en %0d expected 1 15", hs_cnt, en_cnt); end
        checks++; if (ov_cnt !== 1 || last_idx !== 0) begin errors++; $display("[TB] FAIL len1_outputs: got %0d last %0d expected 1 0", ov_cnt, last_idx); end
        checks++; if (done_cyc - t0 !== 19) begin errors++; $display("[TB] FAIL len1_done_cycle: got %0d expected 19", done_cyc - t0); end
        checks++; if (out_bits[0] !== stim[0][1]) begin errors++; $display("[TB] FAIL len1_bit0: got %b expected %b", out_bits[0], stim[0][1]); end
        run_frame(3, 1, 1'b0, 0, fin);
        checks++; if (fin !== 1'b1) begin errors++; $display("[TB] FAIL len3_done_seen: got %0d expected 1", fin); end
        checks++; if (ov_cnt !== 3 || last_idx !== 2 || pace_bad !== 0) begin errors++; $display("[TB] FAIL len3_outputs: got %0d last %0d pace %0d expected 3 2 0", ov_cnt, last_idx, pace_bad); end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (out_bits[j] !== stim[j][1]) begin
                errors++;
                $display("[TB] FAIL len3_bit%0d: got %b expected %b", j, out_bits[j], stim[j][1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_min_frame();
        test_stall();
        test_illegal_len();
        test_max_frame();
        test_reset_mid_frame();
        test_start_while_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
